botao_entrada_debounce: RTL
===========================

Name: botao_entrada_debounce

Overview:
Upstream conditioning stage for the CPU's IN path. It synchronises the raw board push-button and the 4-bit data switches, then debounces the button. On each confirmed press it captures the switch value into a 32-bit zero-extended word and presents it to the CPU's input logic through a valid/ack handshake. It replaces the raw botaoPlaca-to-botaoIN connection and feeds both the halt/resume logic and the IO block.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable clock cycles needed to accept a level change (≥2)
REPEAT_CYCLES, 24'd5000000, hold time before each auto-repeat press (used only with AUTO_REPEAT_EN)
CNT_W, 24, width of internal counters; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
botaoPlaca  input  1  raw push-button, active-high, asynchronous/bouncy
entradaDeDadosIO  input  4  raw data switches, asynchronous
leitura_ack  input  1  CPU consumed dado_entrada this cycle (comandoIN executed)
botao_nivel  output  1  debounced button level
botao_pulso  output  1  one-cycle pulse per accepted press
dado_entrada  output  32  captured switches, {28'd0, sw}
dado_valido  output  1  dado_entrada holds an unconsumed value
sobreposicao  output  1  sticky: a press was accepted while dado_valido=1

Behaviour:
- Reset (async, immediate): all sync flops 0; state SOLTO; counters 0; botao_nivel=0, botao_pulso=0, dado_entrada=0, dado_valido=0, sobreposicao=0.
- Synchroniser: 2-flop chain on botaoPlaca and on each switch bit. Raw→synchronised latency is 2 cycles.
- FSM states: SOLTO, FILTRA_PRESS, PRESSIONADO, FILTRA_SOLTA.
  - SOLTO: sync button=1 → FILTRA_PRESS, counter=1.
  - FILTRA_PRESS: sync=1 → counter+1. When counter reaches DEBOUNCE_CYCLES → PRESSIONADO and accept the press. sync=0 → SOLTO, counter=0 (bounce rejected).
  - PRESSIONADO: sync=0 → FILTRA_SOLTA, counter=1.
  - FILTRA_SOLTA: sync=0 → counter+1. At DEBOUNCE_CYCLES → SOLTO. sync=1 → PRESSIONADO, counter=0.
- botao_nivel=1 in PRESSIONADO and FILTRA_SOLTA, 0 otherwise.
- Accepting a press (registered; all effects in the cycle after the terminal count):
  - botao_pulso=1 for exactly one cycle.
  - If dado_valido=0: dado_entrada <= {28'd0, sync switches}; dado_valido <= 1.
  - If dado_valido=1: dado_entrada is unchanged (oldest value kept); sobreposicao <= 1, sticky until reset.
- Handshake:
  - leitura_ack=1 with dado_valido=1 → dado_valido <= 0 next cycle. dado_entrada holds its value.
  - leitura_ack with dado_valido=0 is ignored.
  - Same-cycle accepted press and leitura_ack: the ack clears the old value and the new value is captured. Result is dado_valido=1 with the new data; no sobreposicao.
- Total latency from a clean press edge to botao_pulso: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Counters saturate and never wrap. A glitch shorter than DEBOUNCE_CYCLES never produces a pulse.
- Reset asserted mid-filter or mid-hold: returns to SOLTO. A button still held at reset release is treated as a fresh press after debounce.

Optional Feature:
AUTO_REPEAT_EN
- Defined: while in PRESSIONADO, a repeat counter increments each cycle. Each time it reaches REPEAT_CYCLES it resets to 0 and generates a further accepted press, with the same capture/overflow rules. The counter clears on leaving PRESSIONADO.
- Undefined: no repeat counter logic; exactly one accepted press per physical press. REPEAT_CYCLES is unused.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10):
- Reset released, switches=4'hA, clean press held 20 cycles → one botao_pulso 7 cycles after the edge; dado_entrada=32'h0000000A; dado_valido=1; botao_nivel=1.
- Bounce: button 1 for 2 cycles, 0 for 1 cycle, repeated 5 times, then stable 0 → no botao_pulso; dado_valido stays 0; state returns to SOLTO.
- Press with sw=4'h3, no ack, then second press with sw=4'h5 → dado_entrada stays 32'h3; sobreposicao=1. Then ack → dado_valido=0 and sobreposicao stays 1.
- Accepted press with sw=4'h7 coincides with leitura_ack on a pending 32'h2 → next cycle dado_entrada=32'h7, dado_valido=1, sobreposicao=0.
- Reset pulsed during FILTRA_PRESS (counter=3) with button still held → all outputs 0 immediately; after release of reset, press accepted 7 cycles later.
- With AUTO_REPEAT_EN, hold button 40 cycles, acking every pulse → 1 initial pulse plus 3 repeat pulses spaced 10 cycles apart. Without the macro → exactly 1 pulse.

Source files
------------

// File: rtl/botao_entrada_debounce.sv
// botao_entrada_debounce: conditioning stage for the CPU IN path.
// Synchronises the raw push-button and the data switches, then debounces the button.
// Each accepted press latches {28'd0, switches} into a valid/ack mailbox.
// The oldest unread value is kept, and a press that arrives while the mailbox
// is still full sets the sticky sobreposicao flag.
// Optional feature macro: AUTO_REPEAT_EN. When it is defined, a held button
// produces a further accepted press every REPEAT_CYCLES cycles.
//
// state        | meaning
// -------------+------------------------------------------------------------
// SOLTO        | button released and stable
// FILTRA_PRESS | button seen high, counting stable-high samples
// PRESSIONADO  | press accepted, button held
// FILTRA_SOLTA | button seen low while held, counting stable-low samples
module botao_entrada_debounce #(
  parameter int unsigned CNT_W           = 24,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        botaoPlaca,
  input  logic [3:0]  entradaDeDadosIO,
  input  logic        leitura_ack,
  output logic        botao_nivel,
  output logic        botao_pulso,
  output logic [31:0] dado_entrada,
  output logic        dado_valido,
  output logic        sobreposicao
);

  typedef enum logic [1:0] {
    SOLTO        = 2'd0,
    FILTRA_PRESS = 2'd1,
    PRESSIONADO  = 2'd2,
    FILTRA_SOLTA = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  logic             btn_meta_q, btn_sync_q;
  logic [3:0]       sw_meta_q, sw_sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_fsm;
  logic             rep_fire;
  logic             press;
  logic             pulse_q, pulse_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  // Two-flop synchronisers for the button and each switch bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_meta_q  <= 4'd0;
      sw_sync_q  <= 4'd0;
    end else begin
      btn_meta_q <= botaoPlaca;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= entradaDeDadosIO;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Debounce FSM state and filter counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SOLTO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce next-state logic. Reaching the terminal count proves DEBOUNCE_CYCLES
  // stable samples, so the following cycle commits the new level without
  // looking at the synchronised input again.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_fsm = 1'b0;
    case (state_q)
      SOLTO: begin
        if (btn_sync_q) begin
          state_d = FILTRA_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      FILTRA_PRESS: begin
        if (cnt_q >= DEB_TC) begin
          state_d   = PRESSIONADO;
          cnt_d     = '0;
          press_fsm = 1'b1;
        end else if (!btn_sync_q) begin
          state_d = SOLTO;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PRESSIONADO: begin
        if (!btn_sync_q) begin
          state_d = FILTRA_SOLTA;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      FILTRA_SOLTA: begin
        if (cnt_q >= DEB_TC) begin
          state_d = SOLTO;
          cnt_d   = '0;
        end else if (btn_sync_q) begin
          state_d = PRESSIONADO;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = SOLTO;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 24'd1);

  logic [CNT_W-1:0] rep_q, rep_d;

  // Repeat timer: runs only while the button stays in PRESSIONADO, cleared otherwise.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q == PRESSIONADO && btn_sync_q) begin
      if (rep_q >= REP_LAST) begin
        rep_fire = 1'b1;
      end else begin
        rep_d = sat_inc(rep_q);
      end
    end
  end

  // Repeat timer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign press = press_fsm | rep_fire;

  // Mailbox update. An ack in the same cycle as a press frees the slot for the new value.
  always_comb begin
    pulse_d = press;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (press) begin
      if (!valid_q || leitura_ack) begin
        data_d  = {28'd0, sw_sync_q};
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (leitura_ack) begin
      valid_d = 1'b0;
    end
  end

  // Mailbox and pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_q <= 1'b0;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign botao_nivel  = (state_q == PRESSIONADO) || (state_q == FILTRA_SOLTA);
  assign botao_pulso  = pulse_q;
  assign dado_entrada = data_q;
  assign dado_valido  = valid_q;
  assign sobreposicao = ovf_q;

endmodule
